// File: rtl/lock_pkg.sv
// Shared encodings and widths for the password-lock blocks.
package lock_pkg;

    localparam int REMAIN_W = 6;
    localparam int FAIL_W   = 2;

    typedef enum logic [1:0] {
        ST_READY   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2
    } lock_state_e;

endpackage

// File: rtl/lock_access_ctrl_if.sv
// Verify-result / policy-status bundle between the lock controller and its neighbours.
interface lock_access_ctrl_if;
    import lock_pkg::*;

    logic                verify_done;
    logic                verify_match;
    logic                admin_clear;
    logic                input_allow;
    logic                set_code_allow;
    logic                lock_open;
    logic                lockout;
    logic                alarm;
    logic [FAIL_W-1:0]   fail_cnt;
    logic [REMAIN_W-1:0] remain_sec;

    modport master (
        output verify_done, verify_match, admin_clear,
        input  input_allow, set_code_allow, lock_open, lockout, alarm, fail_cnt, remain_sec
    );

    modport slave (
        input  verify_done, verify_match, admin_clear,
        output input_allow, set_code_allow, lock_open, lockout, alarm, fail_cnt, remain_sec
    );

endinterface

// File: rtl/lock_access_ctrl_sec_tick.sv
// One-second tick generator; restarts from zero on clr so each timed window
// begins with a full second. half marks the mid-second point.
module sec_tick #(
    parameter int unsigned TICK_THRESHOLD = 100000000 - 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic tick,
    output logic half
);

    localparam int CW = (TICK_THRESHOLD > 0) ? $clog2(TICK_THRESHOLD + 1) : 1;
    localparam logic [CW-1:0] TOP = CW'(TICK_THRESHOLD);
    localparam logic [CW-1:0] MID = CW'(TICK_THRESHOLD / 2);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (clr || !run)
            r_cnt <= '0;
        else if (r_cnt == TOP)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign tick = run && (r_cnt == TOP);
    assign half = run && (r_cnt == MID);

endmodule

// File: rtl/lock_access_ctrl.sv
// Lock access policy: timed open window, mismatch counting with timed lockout,
// entry gating and remaining-seconds/alarm status. Optional: ALARM_BLINK_EN.
module lock_access_ctrl
    import lock_pkg::*;
#(
    parameter int unsigned TICK_THRESHOLD = 100000000 - 1,
    parameter int unsigned OPEN_SECONDS   = 5,
    parameter int unsigned LOCK_SECONDS   = 30,
    parameter int unsigned MAX_FAIL       = 3
) (
    input  logic               clk,
    input  logic               reset,
    lock_access_ctrl_if.slave  bus
);

    localparam logic [REMAIN_W-1:0] OPEN_S = REMAIN_W'(OPEN_SECONDS);
    localparam logic [REMAIN_W-1:0] LOCK_S = REMAIN_W'(LOCK_SECONDS);
    localparam logic [FAIL_W:0]     MAXF_W = (FAIL_W + 1)'(MAX_FAIL);

    lock_state_e         r_state, w_state_nxt;
    logic [FAIL_W-1:0]   r_fail_cnt, w_fail_nxt;
    logic [REMAIN_W-1:0] r_remain, w_remain_nxt;
    logic [FAIL_W:0]     w_fail_inc;
    logic                w_tick, w_half, w_clr, w_run;

    assign w_run      = (r_state == ST_OPEN) || (r_state == ST_LOCKOUT);
    assign w_clr      = bus.admin_clear || (w_state_nxt != r_state);
    assign w_fail_inc = {1'b0, r_fail_cnt} + 1'b1;

    sec_tick #(
        .TICK_THRESHOLD (TICK_THRESHOLD)
    ) u_sec_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .run   (w_run),
        .tick  (w_tick),
        .half  (w_half)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_READY;
            r_fail_cnt <= '0;
            r_remain   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fail_cnt <= w_fail_nxt;
            r_remain   <= w_remain_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_fail_nxt   = r_fail_cnt;
        w_remain_nxt = r_remain;
        // admin_clear wins over any verify result landing in the same cycle
        if (bus.admin_clear) begin
            w_state_nxt  = ST_READY;
            w_fail_nxt   = '0;
            w_remain_nxt = '0;
        end else begin
            case (r_state)
                ST_READY: begin
                    if (bus.verify_done) begin
                        if (bus.verify_match) begin
                            w_state_nxt  = ST_OPEN;
                            w_fail_nxt   = '0;
                            w_remain_nxt = OPEN_S;
                        end else if (w_fail_inc >= MAXF_W) begin
                            w_state_nxt  = ST_LOCKOUT;
                            w_fail_nxt   = MAXF_W[FAIL_W-1:0];
                            w_remain_nxt = LOCK_S;
                        end else begin
                            w_fail_nxt   = w_fail_inc[FAIL_W-1:0];
                        end
                    end
                end
                ST_OPEN: begin
                    if (w_tick) begin
                        if (r_remain <= 1) begin
                            w_state_nxt  = ST_READY;
                            w_remain_nxt = '0;
                        end else begin
                            w_remain_nxt = r_remain - 1'b1;
                        end
                    end
                end
                ST_LOCKOUT: begin
                    if (w_tick) begin
                        if (r_remain <= 1) begin
                            w_state_nxt  = ST_READY;
                            w_remain_nxt = '0;
                            w_fail_nxt   = '0;
                        end else begin
                            w_remain_nxt = r_remain - 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt  = ST_READY;
                    w_fail_nxt   = '0;
                    w_remain_nxt = '0;
                end
            endcase
        end
    end

    assign bus.input_allow    = (r_state == ST_READY);
    assign bus.set_code_allow = (r_state == ST_OPEN);
    assign bus.lock_open      = (r_state == ST_OPEN);
    assign bus.lockout        = (r_state == ST_LOCKOUT);
    assign bus.fail_cnt       = r_fail_cnt;
    assign bus.remain_sec     = r_remain;

`ifdef ALARM_BLINK_EN
    logic r_alarm;

    // toggles on both the mid-second and full-second marks for a 1 Hz blink
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_alarm <= 1'b0;
        else if (w_state_nxt != ST_LOCKOUT)
            r_alarm <= 1'b0;
        else if (r_state != ST_LOCKOUT)
            r_alarm <= 1'b1;
        else if (w_tick || w_half)
            r_alarm <= ~r_alarm;
    end

    assign bus.alarm = r_alarm;
`else
    logic w_unused_half;
    assign w_unused_half = w_half;
    assign bus.alarm     = (r_state == ST_LOCKOUT);
`endif

endmodule

// File: tb/tb_lock_access_ctrl.sv
// Directed bench for lock_access_ctrl at 10 cycles per second.
module tb_lock_access_ctrl;
    import lock_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    lock_access_ctrl_if u_if ();

    lock_access_ctrl #(
        .TICK_THRESHOLD (9),
        .OPEN_SECONDS   (3),
        .LOCK_SECONDS   (5),
        .MAX_FAIL       (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ALARM_BLINK_EN
    localparam logic BLINK = 1'b1;
`else
    localparam logic BLINK = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic m);
        u_if.verify_done  = 1'b1;
        u_if.verify_match = m;
        step(1);
        u_if.verify_done  = 1'b0;
        u_if.verify_match = 1'b0;
    endtask

    task automatic admin();
        u_if.admin_clear = 1'b1;
        step(1);
        u_if.admin_clear = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        u_if.verify_done  = 1'b0;
        u_if.verify_match = 1'b0;
        u_if.admin_clear  = 1'b0;

        // reset values
        step(2);
        check("rst_input_allow", u_if.input_allow, 1);
        check("rst_set_code", u_if.set_code_allow, 0);
        check("rst_lock_open", u_if.lock_open, 0);
        check("rst_lockout", u_if.lockout, 0);
        check("rst_alarm", u_if.alarm, 0);
        check("rst_fail", u_if.fail_cnt, 0);
        check("rst_remain", u_if.remain_sec, 0);
        reset = 1'b0;
        step(1);

        // correct code, full open window
        pulse(1'b1);
        check("open_lock", u_if.lock_open, 1);
        check("open_setcode", u_if.set_code_allow, 1);
        check("open_input", u_if.input_allow, 0);
        check("open_remain3", u_if.remain_sec, 3);
        step(9);
        check("open_remain3_t9", u_if.remain_sec, 3);
        step(1);
        check("open_remain2_t10", u_if.remain_sec, 2);
        step(10);
        check("open_remain1_t20", u_if.remain_sec, 1);
        step(9);
        check("open_still_t29", u_if.lock_open, 1);
        step(1);
        check("open_remain0_t30", u_if.remain_sec, 0);
        check("open_ready_t30", u_if.input_allow, 1);
        check("open_closed_t30", u_if.lock_open, 0);

        // verify ignored in OPEN, admin relocks
        pulse(1'b1);
        pulse(1'b0);
        check("open_ign_fail", u_if.fail_cnt, 0);
        check("open_ign_remain", u_if.remain_sec, 3);
        check("open_ign_lock", u_if.lock_open, 1);
        admin();
        check("admin_open_lock", u_if.lock_open, 0);
        check("admin_open_ready", u_if.input_allow, 1);
        check("admin_open_remain", u_if.remain_sec, 0);

        // three mismatches into lockout
        pulse(1'b0);
        check("mm1_fail", u_if.fail_cnt, 1);
        check("mm1_ready", u_if.input_allow, 1);
        pulse(1'b0);
        check("mm2_fail", u_if.fail_cnt, 2);
        pulse(1'b0);
        check("lk_lockout", u_if.lockout, 1);
        check("lk_remain5", u_if.remain_sec, 5);
        check("lk_fail3", u_if.fail_cnt, 3);
        check("lk_input", u_if.input_allow, 0);
        check("lk_setcode", u_if.set_code_allow, 0);
        check("lk_alarm_t0", u_if.alarm, 1);
        pulse(1'b1);
        check("lk_ign_remain", u_if.remain_sec, 5);
        check("lk_ign_fail", u_if.fail_cnt, 3);
        check("lk_ign_state", u_if.lockout, 1);
        step(3);
        check("lk_alarm_t4", u_if.alarm, 1);
        step(1);
        check("lk_alarm_t5", u_if.alarm, BLINK ? 0 : 1);
        step(4);
        check("lk_remain5_t9", u_if.remain_sec, 5);
        step(1);
        check("lk_remain4_t10", u_if.remain_sec, 4);
        check("lk_alarm_t10", u_if.alarm, 1);
        step(39);
        check("lk_remain1_t49", u_if.remain_sec, 1);
        check("lk_still_t49", u_if.lockout, 1);
        step(1);
        check("lk_exit_ready", u_if.input_allow, 1);
        check("lk_exit_fail", u_if.fail_cnt, 0);
        check("lk_exit_remain", u_if.remain_sec, 0);
        check("lk_exit_alarm", u_if.alarm, 0);

        // admin_clear beats a simultaneous third mismatch
        pulse(1'b0);
        pulse(1'b0);
        check("pre_admin_fail2", u_if.fail_cnt, 2);
        u_if.verify_done  = 1'b1;
        u_if.verify_match = 1'b0;
        u_if.admin_clear  = 1'b1;
        step(1);
        u_if.verify_done  = 1'b0;
        u_if.admin_clear  = 1'b0;
        check("admin_mm_lockout", u_if.lockout, 0);
        check("admin_mm_fail", u_if.fail_cnt, 0);
        check("admin_mm_ready", u_if.input_allow, 1);

        // admin_clear at remain_sec=4 in lockout
        pulse(1'b0);
        pulse(1'b0);
        pulse(1'b0);
        step(10);
        check("lk2_remain4", u_if.remain_sec, 4);
        admin();
        check("admin_lk_ready", u_if.input_allow, 1);
        check("admin_lk_lockout", u_if.lockout, 0);
        check("admin_lk_remain", u_if.remain_sec, 0);
        check("admin_lk_fail", u_if.fail_cnt, 0);
        check("admin_lk_alarm", u_if.alarm, 0);

        // async reset between edges mid-lockout
        pulse(1'b0);
        pulse(1'b0);
        pulse(1'b0);
        step(3);
        check("lk3_active", u_if.lockout, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_input", u_if.input_allow, 1);
        check("arst_lockout", u_if.lockout, 0);
        check("arst_alarm", u_if.alarm, 0);
        check("arst_fail", u_if.fail_cnt, 0);
        check("arst_remain", u_if.remain_sec, 0);
        check("arst_lock", u_if.lock_open, 0);
        step(1);
        reset = 1'b0;
        step(1);
        pulse(1'b1);
        check("post_rst_open", u_if.lock_open, 1);
        check("post_rst_remain", u_if.remain_sec, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lock_access_ctrl.md
Name: lock_access_ctrl

Overview:
Access-sequencing controller for the password lock. Consumes the one-cycle verify result from the main work path and owns the policy:
- Opens the lock for a timed window on a match.
- Counts mismatches and enforces a timed lockout after too many failures.
- Gates when keypad entry and code setting are permitted.
- Supplies remaining-seconds and alarm status to the LED/display path.

Parameters:
TICK_THRESHOLD, 100000000-1, clk cycles per 1 s tick minus one (100 MHz clock)
OPEN_SECONDS, 5, seconds the lock stays open after a match; legal range 1..63
LOCK_SECONDS, 30, lockout duration in seconds; legal range 1..63
MAX_FAIL, 3, consecutive mismatches that trigger lockout; legal range 1..3

Ports:
clk  in  1  system clock, single clock domain
reset  in  1  asynchronous, active-high reset
verify_done  in  1  one-cycle pulse: a password comparison finished
verify_match  in  1  comparison result, valid only when verify_done=1
admin_clear  in  1  one-cycle pulse (already debounced): clear failures and force READY
input_allow  out  1  keypad/input_button entry permitted
set_code_allow  out  1  set_code_button action permitted
lock_open  out  1  lock actuator/open indication
lockout  out  1  lockout active
alarm  out  1  alarm indicator
fail_cnt  out  2  consecutive mismatch count, saturates at MAX_FAIL
remain_sec  out  6  seconds remaining in OPEN or LOCKOUT; 0 in READY

Behaviour:
- States (2-bit): READY=0, OPEN=1, LOCKOUT=2. Code 3 is illegal and recovers to READY on the next clk.
- Reset (async): state=READY, fail_cnt=0, remain_sec=0, tick counter=0.
- Decoded outputs after reset: input_allow=1, set_code_allow=0, lock_open=0, lockout=0, alarm=0.
- Output decode:
  - input_allow = (state==READY)
  - set_code_allow = lock_open = (state==OPEN)
  - lockout = (state==LOCKOUT)
- Registered outputs update on the clk edge after the triggering input. Latency is one cycle.
- Tick counter:
  - Runs only in OPEN or LOCKOUT; cleared on every state entry.
  - When the count equals TICK_THRESHOLD, tick=1 for one cycle and the count returns to 0.
  - As a result, the first second after entry is a full TICK_THRESHOLD+1 cycles.
- READY:
  - verify_done and match: fail_cnt<=0, remain_sec<=OPEN_SECONDS, go to OPEN.
  - verify_done and mismatch: fail_cnt<=fail_cnt+1.
    - If fail_cnt+1==MAX_FAIL: remain_sec<=LOCK_SECONDS, go to LOCKOUT. fail_cnt holds MAX_FAIL.
- OPEN:
  - verify_done is ignored.
  - On tick: remain_sec decrements. A tick while remain_sec==1 sets remain_sec<=0 and goes to READY.
- LOCKOUT:
  - verify_done is ignored.
  - On tick: remain_sec decrements. Expiry sets fail_cnt<=0 and goes to READY.
- admin_clear, any state: next state READY, fail_cnt<=0, remain_sec<=0, tick counter<=0.
  - admin_clear has priority over a simultaneous verify_done; that verify result is discarded.
  - admin_clear in OPEN relocks immediately.
- remain_sec never underflows. fail_cnt never exceeds MAX_FAIL.
- Async reset mid-OPEN or mid-LOCKOUT returns the block to the reset values immediately.

Optional Feature:
ALARM_BLINK_EN:
- Defined: alarm toggles every half second while in LOCKOUT (second counter compare at TICK_THRESHOLD/2), giving a 1 Hz blink. alarm starts at 1 on LOCKOUT entry and is 0 outside LOCKOUT.
- Undefined: alarm = lockout (steady).

Decomposition:
- Package lock_pkg holds the state encoding constants (ST_READY, ST_OPEN, ST_LOCKOUT) and widths (REMAIN_W=6, FAIL_W=2). Other lock blocks share these.
- Sub-module sec_tick owns the tick counter. Ports: clk, reset, clr, run, tick, half. Parameter: TICK_THRESHOLD.

Test Plan:
Use TICK_THRESHOLD=9 (10 cycles/s), OPEN_SECONDS=3, LOCK_SECONDS=5, MAX_FAIL=3.
1. Correct code: verify_done=1, verify_match=1 -> next cycle lock_open=1, remain_sec=3, input_allow=0. Then remain_sec goes 2, 1, 0 at cycles +10, +20, +30, with READY reached at +30.
2. Three mismatches: fail_cnt goes 1, 2, then lockout=1 with remain_sec=5 and input_allow=0. READY and fail_cnt=0 follow 50 cycles after entry.
3. verify_done pulses during OPEN and during LOCKOUT -> fail_cnt and remain_sec unchanged.
4. admin_clear in the same cycle as a mismatch with fail_cnt=2 -> READY, fail_cnt=0, no lockout. Also, admin_clear at remain_sec=4 in LOCKOUT -> READY next cycle.
5. Async reset asserted mid-LOCKOUT between clk edges -> all outputs at reset values before the next edge.
6. ALARM_BLINK_EN defined: alarm toggles every 5 cycles in LOCKOUT. Undefined: alarm equals lockout.
